pbit_array: RTL and testbench

- Parametrised array of N_PBITS probabilistic bits. Each channel takes a signed fixed-point input z_i and outputs 1 with probability (1 + hardtanh(z_i))/2.
- Sits between the weight/bias accumulator (which drives z) and the state register of the probabilistic computer.
- Supports two update schedules:
  - parallel: all channels update on every strobe.
  - sequential (Gibbs): one channel per strobe, round-robin.
- Each channel has its own seedable LFSR. The block tracks sweeps and counts them.

---
 rtl/pbit_array.sv | 193 +++++++++++++++++++
 tb/tb_pbit_array.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_array.sv
// -----------------------------------------------------------------------------
// pbit_array
//
// An array of N_PBITS probabilistic bits. Channel i samples a signed
// fixed-point input z_i and becomes 1 with probability
// (1 + hardtanh(z_i)) / 2. It does this by comparing the clamped input
// against a uniform random value taken from a private Galois LFSR.
//
// The block supports two update schedules:
//   - parallel (mode=0): every channel updates on each strobe.
//   - sequential (mode=1, Gibbs): one channel per strobe, in round-robin.
// Completed sweeps are flagged with a one-cycle pulse and counted by a
// saturating counter.
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset; has priority over en
//   en         in   update strobe; one update event per cycle it is high
//   mode       in   0 = parallel, 1 = sequential
//   z          in   N_PBITS packed two's-complement words of W bits;
//                   channel i occupies bits [(i+1)*W-1 : i*W]
//   pbit_val   out  registered p-bit states, bit i = channel i
//   upd_idx    out  channel touched by the latest strobe (0 in parallel)
//   sweep_done out  one-cycle pulse after a sweep-completing update
//   sweep_cnt  out  number of completed sweeps, saturating
//
// RNG_WIDTH must be at least FLOAT_SIZE+1. INT_SIZE must be at least 2 so
// that +1.0 is representable.
// -----------------------------------------------------------------------------
module pbit_array #(
  parameter int          N_PBITS    = 4,
  parameter int          INT_SIZE   = 8,
  parameter int          FLOAT_SIZE = 24,
  parameter int          RNG_WIDTH  = 32,
  parameter logic [31:0] SEED       = 32'hACE1_2468,
  parameter int          CNT_WIDTH  = 16,
  localparam int         W          = INT_SIZE + FLOAT_SIZE,
  localparam int         IDX_W      = (N_PBITS > 1) ? $clog2(N_PBITS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   en,
  input  logic                   mode,
  input  logic [N_PBITS*W-1:0]   z,
  output logic [N_PBITS-1:0]     pbit_val,
  output logic [IDX_W-1:0]       upd_idx,
  output logic                   sweep_done,
  output logic [CNT_WIDTH-1:0]   sweep_cnt
);

  // Galois feedback mask for x^32+x^22+x^2+x+1. The state shifts right and
  // the mask is folded in whenever a 1 drops out of bit 0.
  localparam logic [RNG_WIDTH-1:0] LFSR_TAPS = RNG_WIDTH'(32'h8020_0003);

  // +1.0 and -1.0 in the W-bit Q(INT_SIZE).(FLOAT_SIZE) format of z.
  localparam logic signed [W-1:0] POS_ONE = W'(1) << FLOAT_SIZE;
  localparam logic signed [W-1:0] NEG_ONE = -POS_ONE;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Per-channel seed. Channels are decorrelated by the golden-ratio
  // constant. The all-zero state is a lock-up state for the LFSR, so it is
  // replaced by 1.
  function automatic logic [RNG_WIDTH-1:0] lfsr_seed(input int unsigned idx);
    logic [31:0]          mix;
    logic [RNG_WIDTH-1:0] s;
    mix = SEED ^ (32'(idx) * 32'h9E37_79B9);
    s   = RNG_WIDTH'(mix);
    if (s == '0) begin
      s = {{(RNG_WIDTH-1){1'b0}}, 1'b1};
    end
    return s;
  endfunction

  function automatic logic [RNG_WIDTH-1:0] lfsr_step(input logic [RNG_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // hardtanh: saturate z to the closed interval [-1.0, +1.0].
  function automatic logic signed [W-1:0] clamp_unit(input logic signed [W-1:0] v);
    if (v > POS_ONE) begin
      return POS_ONE;
    end else if (v < NEG_ONE) begin
      return NEG_ONE;
    end
    return v;
  endfunction

  // The low FLOAT_SIZE+1 LFSR bits are read as a signed fraction in the
  // range [-1, 1-2^-FLOAT_SIZE], then sign-extended to the width of z.
  function automatic logic signed [W-1:0] rng_to_fixed(input logic [RNG_WIDTH-1:0] s);
    logic [FLOAT_SIZE:0] frac;
    frac = s[FLOAT_SIZE:0];
    return {{(W-FLOAT_SIZE-1){frac[FLOAT_SIZE]}}, frac};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [RNG_WIDTH-1:0] r_lfsr [N_PBITS];
  logic [N_PBITS-1:0]   r_pbit;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_mode_prev;

  logic                 w_mode_chg;
  logic [IDX_W-1:0]     w_ptr;
  logic                 w_seq;
  logic                 w_last;
  logic [N_PBITS-1:0]   w_upd;
  logic [N_PBITS-1:0]   w_dec;

  // ---------------------------------------------------------------------------
  // Stage 0: decision logic from the current z and the current LFSR states
  // ---------------------------------------------------------------------------
  always_comb begin
    w_upd      = '0;
    w_dec      = '0;
    // A mode change abandons a partial sweep. The update on this same edge
    // already starts at channel 0.
    w_mode_chg = (mode != r_mode_prev);
    w_ptr      = w_mode_chg ? '0 : r_ptr;
    // With a single channel, a sequential sweep is the same as a parallel
    // update.
    w_seq      = mode && (N_PBITS > 1);
    w_last     = (w_ptr == IDX_W'(N_PBITS - 1));
    for (int i = 0; i < N_PBITS; i++) begin
      w_upd[i] = en && (!w_seq || (w_ptr == IDX_W'(i)));
      // Strict signed compare: a clamped +1.0 always exceeds r, and a
      // clamped -1.0 never does.
      w_dec[i] = clamp_unit(z[i*W +: W]) > rng_to_fixed(r_lfsr[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered p-bit states, LFSRs and sweep bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pbit      <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_mode_prev <= mode;
      for (int i = 0; i < N_PBITS; i++) begin
        r_lfsr[i] <= lfsr_seed(i);
      end
    end else begin
      r_mode_prev <= mode;
      r_done      <= 1'b0;
      if (w_mode_chg) begin
        r_ptr <= '0;
      end
      if (en) begin
        // Only channels that actually update consume a random number.
        for (int i = 0; i < N_PBITS; i++) begin
          if (w_upd[i]) begin
            r_pbit[i] <= w_dec[i];
            r_lfsr[i] <= lfsr_step(r_lfsr[i]);
          end
        end
        if (!w_seq) begin
          r_idx  <= '0;
          r_ptr  <= '0;
          r_done <= 1'b1;
          r_cnt  <= sat_inc(r_cnt);
        end else begin
          r_idx <= w_ptr;
          r_ptr <= w_last ? '0 : w_ptr + IDX_W'(1);
          if (w_last) begin
            r_done <= 1'b1;
            r_cnt  <= sat_inc(r_cnt);
          end
        end
      end
    end
  end

  assign pbit_val   = r_pbit;
  assign upd_idx    = r_idx;
  assign sweep_done = r_done;
  assign sweep_cnt  = r_cnt;

endmodule

// File: tb/tb_pbit_array.sv
module tb_pbit_array;

  localparam int N  = 4;
  localparam int FS = 24;
  localparam int W  = 32;
  localparam int CW = 12;   // small counter so that saturation is reachable
  localparam logic [31:0] SEED = 32'hACE1_2468;

  localparam logic [31:0] ZP2 = 32'h0200_0000;  // +2.0
  localparam logic [31:0] ZM2 = 32'hFE00_0000;  // -2.0
  localparam logic [31:0] ZP1 = 32'h0100_0000;  // +1.0
  localparam logic [31:0] ZM1 = 32'hFF00_0000;  // -1.0
  localparam logic [31:0] ZPH = 32'h0080_0000;  // +0.5
  localparam logic [31:0] ZMH = 32'hFF80_0000;  // -0.5
  localparam logic [31:0] Z0  = 32'h0000_0000;

  logic            CLK = 1'b0;
  logic            RST;
  logic            en;
  logic            mode;
  logic [N*W-1:0]  z;
  logic [N-1:0]    pbit_val;
  logic [1:0]      upd_idx;
  logic            sweep_done;
  logic [CW-1:0]   sweep_cnt;

  always #5 CLK = ~CLK;

  pbit_array #(
    .N_PBITS(N), .INT_SIZE(8), .FLOAT_SIZE(FS), .RNG_WIDTH(32),
    .SEED(SEED), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .mode(mode), .z(z),
    .pbit_val(pbit_val), .upd_idx(upd_idx),
    .sweep_done(sweep_done), .sweep_cnt(sweep_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int unsigned m_lfsr [N];
  logic [N-1:0] m_pbit;
  int  m_idx;
  bit  m_done;
  int  m_cnt;
  int  m_pos;      // position within the current sequential sweep
  bit  m_mode;

  function automatic int unsigned seed_of(int i);
    int unsigned s;
    s = SEED ^ (int'(i) * 32'h9E37_79B9);
    if (s == 0) s = 1;
    return s;
  endfunction

  function automatic int unsigned next_lfsr(int unsigned l);
    if (l % 2 == 1) return (l / 2) ^ 32'h8020_0003;
    return l / 2;
  endfunction

  // Uniform value r in [-1, 1) with FS fractional bits versus clamp(z).
  function automatic bit decide(int unsigned l, logic [31:0] zi);
    longint span, r, a;
    span = longint'(1) << (FS + 1);
    r = longint'(l) % span;
    if (r >= span / 2) r = r - span;
    a = longint'($signed(zi));
    if (a > span / 2) a = span / 2;
    if (a < -(span / 2)) a = -(span / 2);
    return a > r;
  endfunction

  task automatic model_edge(bit rst, bit e, bit md, logic [N*W-1:0] zv);
    int ch;
    if (rst) begin
      for (int i = 0; i < N; i++) m_lfsr[i] = seed_of(i);
      m_pbit = '0; m_idx = 0; m_done = 0; m_cnt = 0; m_pos = 0; m_mode = md;
      return;
    end
    if (md != m_mode) m_pos = 0;
    m_mode = md;
    m_done = 0;
    if (!e) return;
    if (!md) begin
      for (int i = 0; i < N; i++) begin
        m_pbit[i] = decide(m_lfsr[i], zv[i*W +: W]);
        m_lfsr[i] = next_lfsr(m_lfsr[i]);
      end
      m_idx = 0; m_pos = 0; m_done = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      ch = m_pos;
      m_pbit[ch] = decide(m_lfsr[ch], zv[ch*W +: W]);
      m_lfsr[ch] = next_lfsr(m_lfsr[ch]);
      m_idx = ch;
      m_pos++;
      if (m_pos == N) begin
        m_pos = 0; m_done = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
  endtask

  function automatic logic [63:0] model_vec();
    return {m_pbit, 2'(m_idx), m_done, 12'(m_cnt)};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {pbit_val, upd_idx, sweep_done, sweep_cnt};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(bit r, bit e, bit md, logic [N*W-1:0] zv);
    RST = r; en = e; mode = md; z = zv;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(RST, en, mode, z);
    #1;
  endtask

  function automatic logic [N*W-1:0] all_z(logic [31:0] v);
    return {N{v}};
  endfunction

  function automatic logic [31:0] rand_z();
    case ($urandom_range(0, 3))
      0: return $urandom();
      1, 2: return 32'(int'($urandom_range(0, 50331648)) - 25165824);
      default: begin
        case ($urandom_range(0, 4))
          0: return ZP1;
          1: return ZM1;
          2: return ZP1 + 32'd1;
          3: return ZM1 - 32'd1;
          default: return Z0;
        endcase
      end
    endcase
  endfunction

  typedef struct {
    bit          rst;
    bit          en;
    bit          mode;
    logic [31:0] zc;
    logic [3:0]  pv;
    int          idx;
    bit          done;
    int          cnt;
  } vec_t;

  vec_t tbl [26];

  initial begin
    int bad;
    int ones [N];
    logic [N-1:0] seq_a [50];
    bit md;

    tbl[0]  = '{1, 0, 1, ZP2, 4'b0000, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, ZP2, 4'b0001, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, ZP2, 4'b0011, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, ZP2, 4'b0111, 2, 0, 0};
    tbl[4]  = '{0, 1, 1, ZP2, 4'b1111, 3, 1, 1};
    tbl[5]  = '{0, 1, 1, ZP2, 4'b1111, 0, 0, 1};
    tbl[6]  = '{0, 1, 1, ZP2, 4'b1111, 1, 0, 1};
    tbl[7]  = '{0, 1, 1, ZP2, 4'b1111, 2, 0, 1};
    tbl[8]  = '{0, 1, 1, ZP2, 4'b1111, 3, 1, 2};
    tbl[9]  = '{0, 0, 1, ZP2, 4'b1111, 3, 0, 2};
    tbl[10] = '{0, 1, 1, ZM2, 4'b1110, 0, 0, 2};
    tbl[11] = '{0, 1, 1, ZM2, 4'b1100, 1, 0, 2};
    tbl[12] = '{0, 1, 0, ZP2, 4'b1111, 0, 1, 3};
    tbl[13] = '{0, 1, 1, ZM2, 4'b1110, 0, 0, 3};
    tbl[14] = '{0, 1, 1, ZM2, 4'b1100, 1, 0, 3};
    tbl[15] = '{0, 0, 0, ZP2, 4'b1100, 1, 0, 3};
    tbl[16] = '{0, 1, 1, ZP2, 4'b1101, 0, 0, 3};
    tbl[17] = '{0, 1, 1, ZP2, 4'b1111, 1, 0, 3};
    tbl[18] = '{0, 1, 1, ZP2, 4'b1111, 2, 0, 3};
    tbl[19] = '{0, 1, 1, ZP2, 4'b1111, 3, 1, 4};
    tbl[20] = '{0, 1, 1, ZP2, 4'b1111, 0, 0, 4};
    tbl[21] = '{1, 1, 1, ZP2, 4'b0000, 0, 0, 0};
    tbl[22] = '{0, 0, 1, ZP2, 4'b0000, 0, 0, 0};
    tbl[23] = '{0, 1, 0, ZP1, 4'b1111, 0, 1, 1};
    tbl[24] = '{0, 1, 0, ZM1, 4'b0000, 0, 1, 2};
    tbl[25] = '{0, 1, 0, ZP1, 4'b1111, 0, 1, 3};

    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].rst, tbl[k].en, tbl[k].mode, all_z(tbl[k].zc));
      tick();
      check($sformatf("vec%0d.pbit", k), pbit_val, tbl[k].pv);
      check($sformatf("vec%0d.idx", k), upd_idx, tbl[k].idx);
      check($sformatf("vec%0d.done", k), sweep_done, tbl[k].done);
      check($sformatf("vec%0d.cnt", k), sweep_cnt, tbl[k].cnt);
    end

    // 1000 parallel updates at +2.0, then at -2.0
    for (int pass = 0; pass < 2; pass++) begin
      drive(1, 0, 0, all_z(pass == 0 ? ZP2 : ZM2));
      tick();
      bad = 0;
      drive(0, 1, 0, all_z(pass == 0 ? ZP2 : ZM2));
      for (int c = 0; c < 1000; c++) begin
        tick();
        if (pbit_val !== (pass == 0 ? 4'b1111 : 4'b0000) || sweep_done !== 1'b1) bad++;
      end
      check($sformatf("sat_run%0d.bad_cycles", pass), bad, 0);
      check($sformatf("sat_run%0d.cnt", pass), sweep_cnt, 1000);
    end

    // Statistics at 0.0, +0.5, -0.5 and +1.0; the counter saturates at 4095.
    drive(1, 0, 0, {ZP1, ZMH, ZPH, Z0});
    tick();
    for (int i = 0; i < N; i++) ones[i] = 0;
    bad = 0;
    drive(0, 1, 0, {ZP1, ZMH, ZPH, Z0});
    for (int c = 0; c < 4096; c++) begin
      tick();
      for (int i = 0; i < N; i++) ones[i] += int'(pbit_val[i]);
      if (dut_vec() !== model_vec()) bad++;
    end
    check("stat.model_mismatches", bad, 0);
    check("stat.ch0_in_range", (ones[0] >= 1843 && ones[0] <= 2253), 1);
    check("stat.ch1_in_range", (ones[1] >= 2867 && ones[1] <= 3277), 1);
    check("stat.ch2_in_range", (ones[2] >= 819 && ones[2] <= 1229), 1);
    check("stat.ch3_exact", ones[3], 4096);
    check("stat.cnt_saturated", sweep_cnt, 4095);
    tick();
    check("stat.cnt_stays_saturated", sweep_cnt, 4095);
    check("stat.done_at_saturation", sweep_done, 1);

    // Reset determinism: the same 50-value sequence after each reset.
    for (int run = 0; run < 2; run++) begin
      drive(1, 0, 0, all_z(Z0));
      tick();
      check($sformatf("det%0d.rst_pbit", run), pbit_val, 0);
      check($sformatf("det%0d.rst_idx", run), upd_idx, 0);
      check($sformatf("det%0d.rst_done", run), sweep_done, 0);
      check($sformatf("det%0d.rst_cnt", run), sweep_cnt, 0);
      bad = 0;
      drive(0, 1, 0, all_z(Z0));
      for (int c = 0; c < 50; c++) begin
        tick();
        if (run == 0) seq_a[c] = pbit_val;
        else if (pbit_val !== seq_a[c]) bad++;
        if (dut_vec() !== model_vec()) bad++;
      end
      check($sformatf("det%0d.seq_mismatches", run), bad, 0);
    end

    // Randomized traffic against the model.
    md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) md = ~md;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), md,
            {rand_z(), rand_z(), rand_z(), rand_z()});
      tick();
      check($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
